// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM state encoding and default pattern for the 1010 generator/detector pair
package seq_pkg;
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
    localparam int PAT_W_DEF = 4;
    localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 4'b1010;
endpackage

// File: rtl/seq_bit_shifter.sv
// seq_bit_shifter: pattern bit index with reload/step, last-bit flag and look-ahead bit
// Ports: clk, rst (sync, active high); load reloads index to PAT_W-1; step decrements;
//        last = index is at bit 0; nxt_bit = PATTERN bit at the index being loaded this edge.
module seq_bit_shifter #(
    parameter int PAT_W = 4,
    parameter logic [PAT_W-1:0] PATTERN = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step,
    output logic last,
    output logic nxt_bit
);
    localparam int IW = $clog2(PAT_W);
    logic [IW-1:0] idx, idx_n;
    always_comb idx_n = load ? IW'(PAT_W - 1) : step ? idx - IW'(1) : idx;
    assign last    = idx == '0;
    // Output bit is registered in the top, so it must see the index of the coming cycle.
    assign nxt_bit = PATTERN[idx_n];
    always_ff @(posedge clk) begin
        if (rst) idx <= '0;
        else     idx <= idx_n;
    end
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter, MSB first, repeated reps times with optional gaps
// Ports: clk, rst (sync, active high); start/reps/gap_len request a burst (sampled in IDLE);
//        abort ends a burst at the next edge; data_out/bit_valid serial line; busy in SEND/GAP;
//        done pulses on normal completion; sent_cnt counts fully sent patterns.
// Build option: SEQ_PATTERN_GEN_ERR_INJ_EN adds err_inj, which inverts the bit loaded at that edge.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
`ifdef SEQ_PATTERN_GEN_ERR_INJ_EN
    input  logic             err_inj,
`endif
    output logic             data_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_cnt
);
    state_t state, state_n;
    logic [CNT_W-1:0] reps_q, sent_inc;
    logic [GAP_W-1:0] gap_q, gap_cnt;
    logic last, nxt_bit, load, step, err;
    logic data_out_n, bit_valid_n, busy_n, done_n;

`ifdef SEQ_PATTERN_GEN_ERR_INJ_EN
    assign err = err_inj;
`else
    assign err = 1'b0;
`endif

    assign sent_inc = sent_cnt + CNT_W'(1);
    // Reload on entry to SEND and on wrap after bit 0 (back-to-back patterns).
    assign load = state_n == SEND && (state != SEND || last);
    assign step = state == SEND && !last;

    seq_bit_shifter #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_shifter (
        .clk(clk), .rst(rst), .load(load), .step(step), .last(last), .nxt_bit(nxt_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = (start && reps != '0) ? SEND : IDLE;
            SEND: state_n = abort ? IDLE : !last ? SEND : (sent_inc == reps_q) ? DONE :
                            (gap_q != '0) ? GAP : SEND;
            GAP:  state_n = abort ? IDLE : (gap_cnt == GAP_W'(1)) ? SEND : GAP;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        bit_valid_n = state_n == SEND;
        busy_n      = state_n == SEND || state_n == GAP;
        data_out_n  = bit_valid_n && (nxt_bit ^ err);
        done_n      = state_n == DONE || (state == IDLE && start && reps == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reps_q    <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            sent_cnt  <= '0;
            data_out  <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            data_out  <= data_out_n;
            bit_valid <= bit_valid_n;
            busy      <= busy_n;
            done      <= done_n;
            if (state == IDLE && start) begin
                reps_q   <= reps;
                gap_q    <= gap_len;
                sent_cnt <= '0;
            end else if (state == SEND && last && !abort) begin
                sent_cnt <= sent_inc;
            end
            if (state == SEND && state_n == GAP) gap_cnt <= gap_q;
            else if (state == GAP)               gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end
endmodule
